hw3_ser: RTL and testbench

- Upstream feeder for the HW3 "1101101" sequence detector datapath.
- Accepts parallel words over a valid/ready handshake and buffers them in a small FIFO.
- Serializes each word MSB-first onto a single-bit stream that drives the detector's i_data input, one bit per clock.
- Bursts of words produce a gap-free bit stream. When no data is pending, the serial line idles at 0.

---
 rtl/hw3_ser.sv | 97 +++++++++
 tb/tb_hw3_ser.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/hw3_ser.sv
// Parallel-to-serial feeder for the 1101101 detector: small word FIFO
// followed by an MSB-first shifter that chains words without bubbles.
module hw3_ser #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int LVL_W = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_wvalid,
    output logic             o_wready,
    output logic             o_data,
    output logic             o_data_valid,
    output logic             o_busy,
    output logic [LVL_W-1:0] o_level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [LVL_W-1:0] level;
    logic [0:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             nempty, push, pop, last;

    assign nempty   = (level != '0);
    assign o_wready = (level != LVL_W'(DEPTH));
    assign last     = (cnt == CW'(WIDTH-1));
    // Full FIFO refuses a push even when a pop lands on the same edge.
    assign push     = i_wvalid && o_wready && !i_clr;
    assign pop      = !i_clr && nempty && ((state == S_IDLE) || last);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (i_clr) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wptr] <= i_wdata;
    end

    // Loading the next word at cnt==WIDTH-1 keeps the stream gap-free.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else if (i_clr) begin
            state <= S_IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else if (pop) begin
            state <= S_SHIFT;
            shreg <= mem[rptr];
            cnt   <= '0;
        end else if (state == S_SHIFT) begin
            if (last) begin
                state <= S_IDLE;
                shreg <= '0;
                cnt   <= '0;
            end else begin
                shreg <= {shreg[WIDTH-2:0], 1'b0};
                cnt   <= cnt + CW'(1);
            end
        end
    end

    // shreg is zero whenever idle, so the line idles low straight from the flop.
    assign o_data       = shreg[WIDTH-1];
    assign o_data_valid = (state == S_SHIFT);
    assign o_busy       = (state == S_SHIFT) || nempty;
    assign o_level      = level;

endmodule

// File: tb/tb_hw3_ser.sv
// Self-checking bench for hw3_ser: queue-based word/bit model, directed
// scenarios followed by a randomized source with occasional clears.
module tb_hw3_ser;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          wvalid = 1'b0;
    logic [W-1:0]  wdata = '0;
    logic          wready, sdata, svalid, busy;
    logic [LW-1:0] level;

    hw3_ser #(.WIDTH(W), .DEPTH(D), .LVL_W(LW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr),
        .i_wdata(wdata), .i_wvalid(wvalid), .o_wready(wready),
        .o_data(sdata), .o_data_valid(svalid), .o_busy(busy), .o_level(level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: queued words plus the word on the line and how many of its bits remain.
    logic [W-1:0] mq[$];
    logic [W-1:0] cur = '0;
    int           rem = 0;

    // Stream statistics over a window: valid bit count and number of valid runs.
    int  vcnt = 0;
    int  vruns = 0;
    bit  prev_v = 1'b0;
    bit  saw_full = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outs();
        int exp_d;
        exp_d = (rem > 0) ? int'(cur[rem-1]) : 0;
        chk("wready", int'(wready), int'(mq.size() != D));
        chk("level",  int'(level),  mq.size());
        chk("valid",  int'(svalid), int'(rem > 0));
        chk("data",   int'(sdata),  exp_d);
        chk("busy",   int'(busy),   int'(rem > 0 || mq.size() > 0));
        if (svalid && !prev_v) vruns++;
        if (svalid) vcnt++;
        prev_v = svalid;
        if (!wready) saw_full = 1'b1;
    endtask

    task automatic model_edge(output bit acc);
        int sz;
        acc = 1'b0;
        if (!rst_n || clr) begin
            mq.delete();
            rem = 0;
            return;
        end
        sz  = mq.size();
        acc = wvalid && (sz < D);
        if (rem <= 1 && sz > 0) begin
            cur = mq.pop_front();
            rem = W;
        end else if (rem > 0) begin
            rem--;
        end
        if (acc) mq.push_back(wdata);
    endtask

    task automatic cyc(input bit wv, input logic [W-1:0] wd, input bit c, output bit acc);
        wvalid = wv;
        wdata  = wd;
        clr    = c;
        @(negedge clk);
        check_outs();
        @(posedge clk);
        model_edge(acc);
        #1;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, a);
    endtask

    task automatic clr_stats();
        vcnt = 0;
        vruns = 0;
        saw_full = 1'b0;
    endtask

    initial begin
        bit a;
        int idx;
        logic [W-1:0] words[6];
        logic [W-1:0] src;
        bit           have;

        // Reset held for two cycles, then idle after release.
        idle(2);
        rst_n = 1'b1;
        idle(3);

        // Single word 8'hDA.
        clr_stats();
        cyc(1'b1, 8'hDA, 1'b0, a);
        chk("push_da", int'(a), 1);
        idle(12);
        chk("da_bits", vcnt, 8);
        chk("da_runs", vruns, 1);

        // Two words back-to-back: one 16-bit run.
        clr_stats();
        cyc(1'b1, 8'hDB, 1'b0, a);
        cyc(1'b1, 8'h6D, 1'b0, a);
        idle(20);
        chk("b2b_bits", vcnt, 16);
        chk("b2b_runs", vruns, 1);

        // Six words with wvalid held: FIFO fills, nothing lost.
        clr_stats();
        for (int i = 0; i < 6; i++) words[i] = W'(8'h11 * (i + 1));
        idx = 0;
        for (int n = 0; n < 200 && idx < 6; n++) begin
            cyc(1'b1, words[idx], 1'b0, a);
            if (a) idx++;
        end
        chk("six_accepted", idx, 6);
        idle(60);
        chk("six_full_seen", int'(saw_full), 1);
        chk("six_bits", vcnt, 48);
        chk("six_runs", vruns, 1);

        // Clear on the third bit of 8'hFF discards the rest and 8'h0F.
        clr_stats();
        cyc(1'b1, 8'hFF, 1'b0, a);
        cyc(1'b1, 8'h0F, 1'b0, a);
        idle(2);
        cyc(1'b0, '0, 1'b1, a);
        idle(20);
        chk("clr_bits", vcnt, 3);

        // Clear with a push on the same edge drops the push.
        cyc(1'b1, 8'hA5, 1'b1, a);
        chk("clr_push", int'(a), 0);
        idle(3);

        // Asynchronous reset between edges, mid-word.
        cyc(1'b1, 8'hB7, 1'b0, a);
        cyc(1'b1, 8'hC3, 1'b0, a);
        idle(3);
        rst_n = 1'b0;
        #1;
        chk("arst_data",  int'(sdata),  0);
        chk("arst_valid", int'(svalid), 0);
        chk("arst_level", int'(level),  0);
        chk("arst_busy",  int'(busy),   0);
        mq.delete();
        rem = 0;
        idle(2);
        rst_n = 1'b1;
        clr_stats();
        idle(15);
        chk("arst_idle", vcnt, 0);

        // Randomized source that holds its word until accepted.
        have = 1'b0;
        src  = '0;
        for (int n = 0; n < 1500; n++) begin
            bit wv, c;
            if (!have && ($urandom_range(0, 3) != 0)) begin
                src  = W'($urandom());
                have = 1'b1;
            end
            wv = have && ($urandom_range(0, 4) != 0);
            c  = ($urandom_range(0, 59) == 0);
            cyc(wv, src, c, a);
            if (a) have = 1'b0;
        end
        idle(60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
